sub_bytes_iter: RTL and testbench

//  Iterative AES SubBytes stage: takes a 128-bit state, substitutes all 16 bytes through

---
 rtl/aes_pkg.sv | 146 ++++++++++++++
 rtl/sub_bytes_iter_sbox_cf.sv | 57 +++++
 rtl/sub_bytes_iter.sv | 137 +++++++++++++
 tb/tb_sub_bytes_iter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared types, constants and GF arithmetic helpers for the composite-field
// AES S-box datapath.
//
// Field construction:
//   GF(2^4)      : polynomial x^4 + x + 1
//   GF((2^4)^2)  : polynomial y^2 + y + LAMBDA, with LAMBDA = 0xC (trace 1,
//                  so the quadratic is irreducible over GF(2^4))
//   An element is packed {hi, lo} meaning hi*y + lo.
//
// ISO_MAP / ISO_INV_MAP are worked out at elaboration time rather than
// typed in by hand. The code looks for a root r of the AES polynomial
// t^8+t^4+t^3+t+1 in the composite field and sends t^j to r^j. This
// guarantees the map is a field isomorphism for the chosen LAMBDA and
// polynomial. Both are still plain constants: in hardware, each matrix
// product becomes a fixed XOR network.
//
// Matrix layout: mat8_t m, row m[i] is the mask of input bits whose XOR
// forms output bit i.
//
// Optional build macro used by dependents: INV_SBOX_EN (adds InvSubBytes).
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0]       byte_t;
    typedef logic [3:0]       nib_t;
    typedef byte_t [15:0]     state_t;
    typedef logic [7:0][7:0]  mat8_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    localparam byte_t AFF_C     = 8'h63;
    localparam byte_t INV_AFF_C = 8'h05;
    localparam nib_t  LAMBDA    = 4'hC;

    // GF(2^4) multiply, reduction x^4 = x + 1
    function automatic nib_t gf16_mul(input nib_t a, input nib_t b);
        nib_t p;
        nib_t s;
        p = '0;
        s = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ s;
            s = s[3] ? ({s[2:0], 1'b0} ^ 4'h3) : {s[2:0], 1'b0};
        end
        return p;
    endfunction

    function automatic nib_t gf16_sq(input nib_t a);
        return gf16_mul(a, a);
    endfunction

    // a^14 = a^-1 for a != 0; the zero input falls out as zero
    function automatic nib_t gf16_inv(input nib_t a);
        nib_t a2;
        nib_t a4;
        nib_t a8;
        a2 = gf16_sq(a);
        a4 = gf16_sq(a2);
        a8 = gf16_sq(a4);
        return gf16_mul(gf16_mul(a2, a4), a8);
    endfunction

    // Composite-field multiply; only needed to build the isomorphism
    function automatic byte_t cf_mul(input byte_t a, input byte_t b);
        nib_t hh;
        nib_t hi;
        nib_t lo;
        hh = gf16_mul(a[7:4], b[7:4]);
        hi = hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]);
        lo = gf16_mul(hh, LAMBDA) ^ gf16_mul(a[3:0], b[3:0]);
        return {hi, lo};
    endfunction

    function automatic byte_t mat_mul(input mat8_t m, input byte_t a);
        byte_t y;
        for (int i = 0; i < 8; i++) y[i] = ^(m[i] & a);
        return y;
    endfunction

    // Forward affine: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    function automatic byte_t aff_fwd(input byte_t a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ AFF_C;
    endfunction

    // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    function automatic byte_t aff_inv(input byte_t a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ INV_AFF_C;
    endfunction

    function automatic byte_t find_aes_root();
        byte_t r;
        byte_t e;
        byte_t p2;
        byte_t p3;
        byte_t p4;
        byte_t p8;
        r = '0;
        for (int c = 2; c < 256; c++) begin
            e  = byte_t'(c);
            p2 = cf_mul(e, e);
            p3 = cf_mul(p2, e);
            p4 = cf_mul(p2, p2);
            p8 = cf_mul(p4, p4);
            if (r == '0 && (p8 ^ p4 ^ p3 ^ e ^ 8'h01) == '0) r = e;
        end
        return r;
    endfunction

    function automatic mat8_t build_iso_map();
        mat8_t m;
        byte_t r;
        byte_t p;
        r = find_aes_root();
        p = 8'h01;
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 8; i++) m[i][j] = p[i];
            p = cf_mul(p, r);
        end
        return m;
    endfunction

    // Column j of the inverse is the AES byte that maps onto unit vector j
    function automatic mat8_t build_iso_inv_map(input mat8_t fwd);
        mat8_t m;
        byte_t col;
        for (int j = 0; j < 8; j++) begin
            col = '0;
            for (int a = 0; a < 256; a++) begin
                if (mat_mul(fwd, byte_t'(a)) == (byte_t'(1) << j)) col = byte_t'(a);
            end
            for (int i = 0; i < 8; i++) m[i][j] = col[i];
        end
        return m;
    endfunction

    localparam mat8_t ISO_MAP     = build_iso_map();
    localparam mat8_t ISO_INV_MAP = build_iso_inv_map(ISO_MAP);

endpackage

// File: rtl/sub_bytes_iter_sbox_cf.sv
// -----------------------------------------------------------------------------
// sbox_cf
// One combinational composite-field S-box lane without a lookup table.
// Data path: isomorphic map into GF((2^4)^2), inversion there via the GF(2^4)
// inverse, inverse map, then the forward affine step.
//
// Ports:
//   x    in   8  byte to substitute
//   inv  in   1  (INV_SBOX_EN only) 1 = InvSubBytes, 0 = SubBytes
//   y    out  8  substituted byte
//
// Build macro: INV_SBOX_EN. When it is undefined, the lane has no
// inverse-affine logic and no inv port.
// -----------------------------------------------------------------------------
module sbox_cf
    import aes_pkg::*;
(
    input  byte_t x,
`ifdef INV_SBOX_EN
    input  logic  inv,
`endif
    output byte_t y
);

    byte_t pre;
    byte_t iso;
    byte_t back;
    nib_t  h;
    nib_t  l;
    nib_t  d;
    nib_t  d_inv;
    nib_t  inv_h;
    nib_t  inv_l;

    always_comb begin
`ifdef INV_SBOX_EN
        pre = inv ? aff_inv(x) : x;
`else
        pre = x;
`endif
        iso = mat_mul(ISO_MAP, pre);
        h   = iso[7:4];
        l   = iso[3:0];
        // (h*y + l)^-1 = h*d^-1 * y + (h+l)*d^-1,  d = h^2*LAMBDA + h*l + l^2
        d     = gf16_mul(gf16_sq(h), LAMBDA) ^ gf16_mul(h, l) ^ gf16_sq(l);
        d_inv = gf16_inv(d);
        inv_h = gf16_mul(h, d_inv);
        inv_l = gf16_mul(h ^ l, d_inv);
        back  = mat_mul(ISO_INV_MAP, {inv_h, inv_l});
`ifdef INV_SBOX_EN
        y = inv ? back : aff_fwd(back);
`else
        y = aff_fwd(back);
`endif
    end

endmodule

// File: rtl/sub_bytes_iter.sv
// -----------------------------------------------------------------------------
// sub_bytes_iter
// Iterative AES SubBytes. It accepts a 128-bit state and substitutes one
// 32-bit word (four bytes) per cycle using LANES composite-field S-box lanes.
// After four cycles it holds the result until the downstream stage takes it.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    input state valid
//   in_ready   out  1    high only in IDLE
//   in_state   in   128  byte 0 = [127:120] ... byte 15 = [7:0]
//   out_valid  out  1    high in DONE
//   out_ready  in   1    downstream accepts out_state
//   out_state  out  128  substituted state, same byte ordering
//   busy       out  1    any state other than IDLE
//   inv        in   1    (INV_SBOX_EN only) captured at acceptance; 1 = InvSubBytes
//
// Build macro: INV_SBOX_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// RUN   | substituting word cnt_q (0..3) in place, one word per cycle
// DONE  | out_valid high, result held until out_ready
// -----------------------------------------------------------------------------
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
`ifdef INV_SBOX_EN
    ,
    input  logic         inv
`endif
);

    if (LANES != 4) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 4");
    end

    fsm_e        fsm_q;
    fsm_e        fsm_d;
    state_t      st_q;
    logic [1:0]  cnt_q;
    logic        accept;
    logic        advance;
    byte_t       lane_x [LANES];
    byte_t       lane_y [LANES];

`ifdef INV_SBOX_EN
    logic        inv_q;
`endif

    // Byte 4k+l sits at st_q index 15-(4k+l), which for 4-bit values is the
    // bitwise complement of {k, l}.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam logic [1:0] LANE_ID = 2'(g);

        assign lane_x[g] = st_q[~{cnt_q, LANE_ID}];

        sbox_cf u_sbox (
            .x   (lane_x[g]),
`ifdef INV_SBOX_EN
            .inv (inv_q),
`endif
            .y   (lane_y[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d     = fsm_q;
        accept    = 1'b0;
        advance   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept = 1'b1;
                    fsm_d  = RUN;
                end
            end
            RUN: begin
                advance = 1'b1;
                if (cnt_q == 2'd3) fsm_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= '0;
            cnt_q <= '0;
`ifdef INV_SBOX_EN
            inv_q <= 1'b0;
`endif
        end else if (accept) begin
            st_q  <= in_state;
            cnt_q <= '0;
`ifdef INV_SBOX_EN
            inv_q <= inv;
`endif
        end else if (advance) begin
            for (int l = 0; l < LANES; l++) begin
                st_q[~{cnt_q, 2'(l)}] <= lane_y[l];
            end
            // wraps back to 0 on the last word, ready for the next state
            cnt_q <= cnt_q + 2'd1;
        end
    end

    assign out_state = st_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
module tb_sub_bytes_iter;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] ALL_63   = {16{8'h63}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;
    logic         busy;
`ifdef INV_SBOX_EN
    logic         inv = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    sub_bytes_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
`ifdef INV_SBOX_EN
        ,
        .inv       (inv)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] sub_ref(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = s[127-8*i -: 8];
            r[127-8*i -: 8] = SBOX[b];
        end
        return r;
    endfunction

    // Assumes the DUT is idle: accept on the next edge, then wait (bounded) for out_valid
    task automatic send(input logic [127:0] st);
        int waited;
        in_state = st;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        chk_bit("out_valid_wait", out_valid, 1'b1);
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] st;
        logic [127:0] exp;

        // reset state
        tick();
        tick();
        rst = 1'b0;
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_word("rst_out_state", out_state, '0);

        // all-zero state and exact latency: accept, 3 edges low, 4th edge high
        in_state = '0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_bit("t1_busy_after_accept", busy, 1'b1);
        chk_bit("t1_in_ready_after_accept", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_bit("t1_out_valid_early", out_valid, 1'b0);
        end
        tick();
        chk_bit("t1_out_valid_rise", out_valid, 1'b1);
        chk_word("t1_zero_state", out_state, ALL_63);

        // in_valid held across handoff: not taken at the handoff edge, taken on the next
        in_state  = FIPS_IN;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_bit("handoff_idle_in_ready", in_ready, 1'b1);
        chk_bit("handoff_idle_busy", busy, 1'b0);
        chk_word("handoff_state_kept", out_state, ALL_63);
        tick();
        in_valid = 1'b0;
        chk_bit("accept_after_handoff", busy, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk_bit("fips_out_valid", out_valid, 1'b1);
        chk_word("fips_round1", out_state, FIPS_OUT);
        handoff();

        // every byte value through the lanes, 16 states of 16 consecutive bytes
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) st[127-8*i -: 8] = 8'(16*j + i);
            exp = sub_ref(st);
            send(st);
            chk_word($sformatf("lanes_%0d", j), out_state, exp);
            handoff();
        end

        // stall in DONE with extra in_valid traffic
        st  = 128'h00112233445566778899aabbccddeeff;
        exp = sub_ref(st);
        send(st);
        chk_word("stall_result", out_state, exp);
        in_state = ~st;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_word("stall_out_state", out_state, exp);
            chk_bit("stall_in_ready", in_ready, 1'b0);
            chk_bit("stall_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        handoff();
        chk_bit("stall_release_in_ready", in_ready, 1'b1);
        chk_bit("stall_release_out_valid", out_valid, 1'b0);
        chk_word("stall_extra_ignored", out_state, exp);

        // reset while processing word 2
        in_state = FIPS_IN;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_bit("midrst_in_ready", in_ready, 1'b1);
        chk_bit("midrst_out_valid", out_valid, 1'b0);
        chk_bit("midrst_busy", busy, 1'b0);
        chk_word("midrst_out_state", out_state, '0);
        send(FIPS_IN);
        chk_word("midrst_fresh_fips", out_state, FIPS_OUT);
        handoff();

`ifdef INV_SBOX_EN
        inv = 1'b1;
        send(FIPS_OUT);
        inv = 1'b0;
        chk_word("inv_fips", out_state, FIPS_IN);
        handoff();
        inv = 1'b1;
        send({8'h63, 8'hed, {14{8'h63}}});
        inv = 1'b0;
        chk_word("inv_bytes", out_state, {8'h00, 8'h53, {14{8'h00}}});
        handoff();
        send(FIPS_IN);
        chk_word("fwd_after_inv", out_state, FIPS_OUT);
        handoff();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
